// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Purpose  : Matrix keypad scanner. It drives one-cold column strobes and
//            samples the active-low rows through a 2-FF synchronizer. Each
//            key is debounced separately, and each debounced press or release
//            is queued as an event in a first-word-fall-through FIFO.
// Ports    : iclk/inrest   - clock, asynchronous active-low reset
//            iROW          - raw row inputs (active-low, asynchronous)
//            oCOL          - column strobes, exactly one bit low
//            oKEYST        - debounced key state, bit = row*NCOL+col
//            oKEYNUM       - lowest pressed key index + 1 (0 = none)
//            oEV_VALID/iEV_READY/oEV_DATA - event FIFO head handshake
//            oOVF/iOVF_CLR - sticky overflow flag and its clear
//            oIRQ          - FIFO non-empty
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
  parameter int NROW       = 4,
  parameter int NCOL       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 iclk,
  input  logic                 inrest,
  input  logic [NROW-1:0]      iROW,
  output logic [NCOL-1:0]      oCOL,
  output logic [NROW*NCOL-1:0] oKEYST,
  output logic [7:0]           oKEYNUM,
  output logic                 oEV_VALID,
  input  logic                 iEV_READY,
  output logic [7:0]           oEV_DATA,
  output logic                 oOVF,
  input  logic                 iOVF_CLR,
  output logic                 oIRQ
);

  localparam int NKEY = NROW * NCOL;
  localparam int KW   = $clog2(NKEY);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int CLW  = $clog2(NCOL);
  localparam int RW   = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int CW   = $clog2(DEB_SCANS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]  SLOT_PRE  = SW'(SCAN_DIV - 2);
  localparam logic [SW-1:0]  ROW_LAST  = SW'(NROW - 1);
  localparam logic [CLW-1:0] COL_LAST  = CLW'(NCOL - 1);
  localparam logic [CW-1:0]  DEB_MAX   = CW'(DEB_SCANS);
  localparam logic [AW:0]    CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [NROW-1:0] r_row_s1, r_row_s2;
  logic [SW-1:0]   r_slot;
  logic [CLW-1:0]  r_col;
  logic [1:0]      r_state, w_state_nxt;
  logic            w_latch, w_upd;
  logic [NROW-1:0] r_samp;
  logic [CLW-1:0]  r_samp_col;
  logic [NKEY-1:0] r_keyst;
  logic [CW-1:0]   r_cnt [NKEY];
  logic [7:0]      r_keynum, w_keynum;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic [NCOL-1:0] w_col_n;

  // Synchronizer and scan timebase
  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_slot   <= '0;
      r_col    <= '0;
    end else begin
      r_row_s1 <= iROW;
      r_row_s2 <= r_row_s1;
      if (r_slot == SLOT_LAST) begin
        r_slot <= '0;
        r_col  <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  always_comb begin
    w_col_n = '1;
    for (int i = 0; i < NCOL; i++) begin
      if (r_col == CLW'(i)) w_col_n[i] = 1'b0;
    end
  end

  // FSM: SAMPLE coincides with the last clock of a slot; UPDATE covers the
  // first NROW clocks of the next slot, so the slot counter selects the row.
  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_slot == SLOT_PRE) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = ST_UPDATE;
      ST_UPDATE: if (r_slot == ROW_LAST) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch = (r_state == ST_SAMPLE);
    w_upd   = (r_state == ST_UPDATE);
  end

  // Debounce datapath: one key per clock during UPDATE
  logic [RW-1:0] w_row;
  logic [KW-1:0] w_key;
  logic          w_raw, w_stable, w_toggle;
  logic [CW-1:0] w_cnt_inc;
  logic [7:0]    w_push_data;

  always_comb begin
    w_row       = r_slot[RW-1:0];
    w_key       = KW'(int'(w_row) * NCOL + int'(r_samp_col));
    w_raw       = r_samp[w_row];
    w_stable    = r_keyst[w_key];
    w_cnt_inc   = r_cnt[w_key] + 1'b1;
    w_toggle    = w_upd && (w_raw != w_stable) && (w_cnt_inc == DEB_MAX);
    w_push_data = {w_raw, 7'(w_key)};
  end

  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) begin
      r_samp     <= '0;
      r_samp_col <= '0;
      r_keyst    <= '0;
      for (int i = 0; i < NKEY; i++) r_cnt[i] <= '0;
    end else begin
      if (w_latch) begin
        r_samp     <= ~r_row_s2;
        r_samp_col <= r_col;
      end
      if (w_upd) begin
        if (w_raw == w_stable) begin
          r_cnt[w_key] <= '0;
        end else if (w_toggle) begin
          r_cnt[w_key]   <= '0;
          r_keyst[w_key] <= w_raw;
        end else begin
          r_cnt[w_key] <= w_cnt_inc;
        end
      end
    end
  end

  // Lowest pressed key wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_keynum = 8'd0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (r_keyst[i]) w_keynum = 8'(i + 1);
    end
  end

  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) r_keynum <= 8'd0;
    else         r_keynum <= w_keynum;
  end

  // Event FIFO. A pop frees the slot in the same cycle, so a push into a
  // full FIFO is accepted when it coincides with a pop.
  logic w_empty, w_full, w_pop, w_wr, w_drop;

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CNT_FULL);
    w_pop   = !w_empty && iEV_READY;
    w_wr    = w_toggle && (!w_full || w_pop);
    w_drop  = w_toggle && w_full && !w_pop;
  end

  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_drop)        r_ovf <= 1'b1;
      else if (iOVF_CLR) r_ovf <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge iclk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  assign oCOL      = w_col_n;
  assign oKEYST    = r_keyst;
  assign oKEYNUM   = r_keynum;
  assign oEV_VALID = !w_empty;
  assign oEV_DATA  = w_empty ? 8'h00 : r_mem[r_rptr];
  assign oOVF      = r_ovf;
  assign oIRQ      = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Purpose  : Self-checking bench for keypad_scan_fifo. A keypad model turns a
//            pressed-key mask into row levels from the column strobes.
//            Expected events are queued as keys change and compared when the
//            DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

  localparam int FRAME = 32;

  logic        iclk;
  logic        inrest;
  logic [3:0]  iROW;
  logic [3:0]  oCOL;
  logic [15:0] oKEYST;
  logic [7:0]  oKEYNUM;
  logic        oEV_VALID;
  logic        iEV_READY;
  logic [7:0]  oEV_DATA;
  logic        oOVF;
  logic        iOVF_CLR;
  logic        oIRQ;

  logic [15:0] keys;
  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_pass;

  keypad_scan_fifo #(
    .NROW(4), .NCOL(4), .SCAN_DIV(8), .DEB_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .iclk(iclk), .inrest(inrest), .iROW(iROW), .oCOL(oCOL),
    .oKEYST(oKEYST), .oKEYNUM(oKEYNUM), .oEV_VALID(oEV_VALID),
    .iEV_READY(iEV_READY), .oEV_DATA(oEV_DATA), .oOVF(oOVF),
    .iOVF_CLR(iOVF_CLR), .oIRQ(oIRQ)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    iROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !oCOL[c]) iROW[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // Events leave the FIFO on the next edge when valid and ready are both high.
  always @(negedge iclk) begin
    if (inrest && oEV_VALID && iEV_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got %0h expected none", oEV_DATA);
      end else begin
        chk("event", {24'h0, oEV_DATA}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_col_entry(input logic [3:0] pat);
    logic [3:0] prev;
    bit seen;
    prev = oCOL;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick(1);
      if (oCOL == pat && prev != pat) seen = 1'b1;
      prev = oCOL;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL col_wait: got %b expected entry into %b", oCOL, pat);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"},   {28'h0, oCOL},      32'hE);
    chk({tag, "_keyst"}, {16'h0, oKEYST},    32'h0);
    chk({tag, "_keynum"},{24'h0, oKEYNUM},   32'h0);
    chk({tag, "_valid"}, {31'h0, oEV_VALID}, 32'h0);
    chk({tag, "_data"},  {24'h0, oEV_DATA},  32'h0);
    chk({tag, "_ovf"},   {31'h0, oOVF},      32'h0);
    chk({tag, "_irq"},   {31'h0, oIRQ},      32'h0);
  endtask

  typedef struct {
    logic [15:0] mask;
    int          frames;
    logic [15:0] exp_st;
    logic [7:0]  exp_num;
    int          nev;
    logic [7:0]  ev0;
    logic [7:0]  ev1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] ecol;

    // press/release, bounce, dual press in one column
    vecs[0] = '{16'h0040, 4, 16'h0040, 8'd7, 1, 8'h86, 8'h00};
    vecs[1] = '{16'h0000, 4, 16'h0000, 8'd0, 1, 8'h06, 8'h00};
    vecs[2] = '{16'h0040, 2, 16'h0000, 8'd0, 0, 8'h00, 8'h00};
    vecs[3] = '{16'h0000, 1, 16'h0000, 8'd0, 0, 8'h00, 8'h00};
    vecs[4] = '{16'h0040, 4, 16'h0040, 8'd7, 1, 8'h86, 8'h00};
    vecs[5] = '{16'h0000, 4, 16'h0000, 8'd0, 1, 8'h06, 8'h00};
    vecs[6] = '{16'h2002, 4, 16'h2002, 8'd2, 2, 8'h81, 8'h8D};
    vecs[7] = '{16'h0000, 4, 16'h0000, 8'd0, 2, 8'h01, 8'h0D};

    n_checks  = 0;
    n_pass    = 0;
    keys      = 16'h0;
    iEV_READY = 1'b1;
    iOVF_CLR  = 1'b0;
    inrest    = 1'b0;

    // Reset values and column sequence
    tick(3);
    chk_reset_outputs("reset");
    @(negedge iclk);
    inrest = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      tick(1);
      ecol = 4'hF;
      ecol[(m / 8) % 4] = 1'b0;
      chk("col_seq", {28'h0, oCOL}, {28'h0, ecol});
    end
    chk("idle_valid", {31'h0, oEV_VALID}, 32'h0);
    chk("idle_keyst", {16'h0, oKEYST}, 32'h0);

    // Table-driven key sequences
    for (int v = 0; v < 8; v++) begin
      keys = vecs[v].mask;
      if (vecs[v].nev > 0) exp_q.push_back(vecs[v].ev0);
      if (vecs[v].nev > 1) exp_q.push_back(vecs[v].ev1);
      tick(vecs[v].frames * FRAME);
      chk($sformatf("v%0d_keyst", v),  {16'h0, oKEYST},  {16'h0, vecs[v].exp_st});
      chk($sformatf("v%0d_keynum", v), {24'h0, oKEYNUM}, {24'h0, vecs[v].exp_num});
      chk($sformatf("v%0d_pending", v), exp_q.size(), 32'd0);
    end

    // Overflow: fill with 4 presses, a 5th press is dropped
    iEV_READY = 1'b0;
    keys = 16'h1111;
    exp_q.push_back(8'h80); exp_q.push_back(8'h84);
    exp_q.push_back(8'h88); exp_q.push_back(8'h8C);
    tick(4 * FRAME);
    chk("full_valid", {31'h0, oEV_VALID}, 32'h1);
    chk("full_irq",   {31'h0, oIRQ},      32'h1);
    chk("full_ovf",   {31'h0, oOVF},      32'h0);
    keys = 16'h1113;
    tick(4 * FRAME);
    chk("ovf_set",    {31'h0, oOVF},      32'h1);
    chk("ovf_keyst",  {16'h0, oKEYST},    32'h1113);
    chk("ovf_keynum", {24'h0, oKEYNUM},   32'd1);
    iEV_READY = 1'b1;
    tick(8);
    chk("drain_pending", exp_q.size(), 32'd0);
    chk("drain_valid", {31'h0, oEV_VALID}, 32'h0);
    chk("ovf_sticky",  {31'h0, oOVF},      32'h1);
    iOVF_CLR = 1'b1;
    tick(1);
    iOVF_CLR = 1'b0;
    chk("ovf_clr", {31'h0, oOVF}, 32'h0);

    // Full FIFO + pop + push on the same edge: release col0 keys and key 1
    // at the start of a col0 slot, so key 1's release lands on the first
    // clock of the third following col2 slot, right after col0 filled it.
    iEV_READY = 1'b0;
    wait_col_entry(4'b1110);
    keys = 16'h0000;
    exp_q.push_back(8'h00); exp_q.push_back(8'h04);
    exp_q.push_back(8'h08); exp_q.push_back(8'h0C);
    exp_q.push_back(8'h01);
    wait_col_entry(4'b1011);
    wait_col_entry(4'b1011);
    wait_col_entry(4'b1011);
    chk("pp_valid", {31'h0, oEV_VALID}, 32'h1);
    iEV_READY = 1'b1;
    tick(1);
    iEV_READY = 1'b0;
    tick(2);
    chk("pp_no_ovf", {31'h0, oOVF}, 32'h0);
    iEV_READY = 1'b1;
    tick(8);
    chk("pp_pending", exp_q.size(), 32'd0);
    chk("pp_keyst", {16'h0, oKEYST}, 32'h0);

    // Reset mid-UPDATE with events pending
    iEV_READY = 1'b0;
    keys = 16'h0011;
    exp_q.push_back(8'h80); exp_q.push_back(8'h84);
    tick(4 * FRAME);
    chk("rst_pre_valid", {31'h0, oEV_VALID}, 32'h1);
    wait_col_entry(4'b1101);
    #2;
    inrest = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    tick(3);
    iEV_READY = 1'b1;
    @(negedge iclk);
    inrest = 1'b1;
    exp_q.push_back(8'h80); exp_q.push_back(8'h84);
    tick(4 * FRAME);
    chk("rerep_keyst",  {16'h0, oKEYST},  32'h0011);
    chk("rerep_keynum", {24'h0, oKEYNUM}, 32'd1);
    chk("rerep_pending", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
